// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the handshaked ALU control sequencer.
// Contents: OpALU class encodings, R-type funct encodings, 4-bit ALU
// select codes, the sequencer state enum, the decoder result payload and
// the is_multicycle helper.
package alu_ctrl_pkg;

  localparam int unsigned ALU_CODE_W = 4;
  localparam int unsigned OP_W       = 2;
  localparam int unsigned FUNCT_W0   = 6;

  typedef logic [ALU_CODE_W-1:0] alu_code_t;
  typedef logic [OP_W-1:0]       op_t;
  typedef logic [FUNCT_W0-1:0]   funct_t;

  // OpALU classes
  localparam op_t OP_MEM    = 2'b00;
  localparam op_t OP_BRANCH = 2'b01;
  localparam op_t OP_RTYPE  = 2'b10;
  localparam op_t OP_RSVD   = 2'b11;

  // R-type funct encodings
  localparam funct_t F_ADD  = 6'b100000;
  localparam funct_t F_SUB  = 6'b100010;
  localparam funct_t F_AND  = 6'b100100;
  localparam funct_t F_OR   = 6'b100101;
  localparam funct_t F_SLT  = 6'b101010;
  localparam funct_t F_NOR  = 6'b100111;
  localparam funct_t F_MULT = 6'b011000;
  localparam funct_t F_DIV  = 6'b011010;

  // ALU select codes
  localparam alu_code_t ALU_AND  = 4'b0000;
  localparam alu_code_t ALU_OR   = 4'b0001;
  localparam alu_code_t ALU_ADD  = 4'b0010;
  localparam alu_code_t ALU_SUB  = 4'b0110;
  localparam alu_code_t ALU_SLT  = 4'b0111;
  localparam alu_code_t ALU_MULT = 4'b1000;
  localparam alu_code_t ALU_DIV  = 4'b1001;
  localparam alu_code_t ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MULTI = 2'b01,
    HOLD  = 2'b10
  } state_e;

  // Decoder result payload
  typedef struct packed {
    alu_code_t code;
    logic      multi;
    logic      illegal;
  } dec_t;

  function automatic logic is_multicycle(input alu_code_t code);
    return (code == ALU_MULT) || (code == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle between the ID-stage control and the ALU
// control sequencer.
// Signals: in_valid/in_ready/OpALU/funct (request), out_valid/out_ready/
// inputALU (result), busy (multi-cycle op in progress). With
// ALU_CTRL_ILLEGAL_TRAP_EN defined it also carries illegal and err_sticky.
interface alu_ctrl_seq_if #(
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned FUNCT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         OpALU;
  logic [FUNCT_W-1:0] funct;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  inputALU;
  logic               busy;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic               illegal;
  logic               err_sticky;
`endif

  modport master (
    output in_valid, OpALU, funct, out_ready,
    input  in_ready, out_valid, inputALU, busy
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    , input illegal, err_sticky
`endif
  );

  modport slave (
    input  in_valid, OpALU, funct, out_ready,
    output in_ready, out_valid, inputALU, busy
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    , output illegal, err_sticky
`endif
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational (OpALU, funct) -> {code, multicycle, illegal} decoder.
// Ports: op_alu_i (class), funct_i (R-type function), dec_c_o (payload).
// Kept standalone so the hazard unit can reuse it.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_W = 6
) (
  input  logic [1:0]         op_alu_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output dec_t               dec_c_o
);

  // Illegal encodings fall through to code 0000 with the illegal flag set
  always_comb begin
    dec_c_o = '0;
    case (op_alu_i)
      OP_MEM:    dec_c_o.code = ALU_ADD;
      OP_BRANCH: dec_c_o.code = ALU_SUB;
      OP_RTYPE: begin
        case (funct_i)
          FUNCT_W'(F_ADD):  dec_c_o.code = ALU_ADD;
          FUNCT_W'(F_SUB):  dec_c_o.code = ALU_SUB;
          FUNCT_W'(F_AND):  dec_c_o.code = ALU_AND;
          FUNCT_W'(F_OR):   dec_c_o.code = ALU_OR;
          FUNCT_W'(F_SLT):  dec_c_o.code = ALU_SLT;
          FUNCT_W'(F_NOR):  dec_c_o.code = ALU_NOR;
          FUNCT_W'(F_MULT): dec_c_o.code = ALU_MULT;
          FUNCT_W'(F_DIV):  dec_c_o.code = ALU_DIV;
          default:          dec_c_o.illegal = 1'b1;
        endcase
      end
      default: dec_c_o.illegal = 1'b1;
    endcase
    dec_c_o.multi = is_multicycle(dec_c_o.code);
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Handshaked ALU control sequencer: decodes (OpALU, funct) on accept into a
// registered ALU select code, holding it until consumed; MULT/DIV spend a
// fixed latency in MULTI with busy asserted before the result is offered.
// Ports: clk, rst_n (async active-low), bus (alu_ctrl_seq_if.slave).
// Optional: ALU_CTRL_ILLEGAL_TRAP_EN adds registered illegal and sticky
// err_sticky outputs on the bus.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_seq_if.slave bus
);

  localparam int unsigned LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0]  alu_q, alu_d;
  logic               in_ready_c;
  logic               accept_c;
  dec_t               dec;

  alu_ctrl_decode #(.FUNCT_W(FUNCT_W)) u_decode (
    .op_alu_i (bus.OpALU),
    .funct_i  (bus.funct),
    .dec_c_o  (dec)
  );

  // Next-state: counter is loaded with LAT-1 and reaches 0 as MULTI hands
  // over to HOLD, so the result appears LAT cycles after accept.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_d      = alu_q;
    in_ready_c = 1'b0;
    case (state_q)
      IDLE:  in_ready_c = 1'b1;
      MULTI: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = HOLD;
      end
      HOLD: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready && !bus.in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept_c = in_ready_c && bus.in_valid;
    if (accept_c) begin
      alu_d = CTRL_W'(dec.code);
      if (dec.multi) begin
        state_d = MULTI;
        cnt_d   = (dec.code == ALU_MULT) ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);
      end else begin
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q == MULTI);
  assign bus.inputALU  = alu_q;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, err_q;

  // illegal travels with the result; err_sticky only clears on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept_c) begin
      illegal_q <= dec.illegal;
      err_q     <= err_q | dec.illegal;
    end
  end

  assign bus.illegal    = illegal_q;
  assign bus.err_sticky = err_q;
`else
  logic unused_illegal;
  assign unused_illegal = dec.illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_alu_ctrl_seq;
  import alu_ctrl_pkg::*;

  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 8;

  typedef struct packed {
    logic      ill;
    alu_code_t code;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  alu_ctrl_seq_if #(.CTRL_W(CTRL_W), .FUNCT_W(FUNCT_W)) bus ();

  alu_ctrl_seq #(
    .CTRL_W(CTRL_W), .FUNCT_W(FUNCT_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request (called just after a rising edge); returns the number
  // of cycles spent waiting for in_ready and leaves just after the accept edge.
  task automatic send(input op_t op, input funct_t f, input alu_code_t code,
                      input logic ill, output int waited);
    exp_t e;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.OpALU    = op;
    bus.funct    = f;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready never rose for op=%0b funct=%0b", op, f);
      bus.in_valid = 1'b0;
    end else begin
      e.ill  = ill;
      e.code = code;
      exp_q.push_back(e);
      tick();
      bus.in_valid = 1'b0;
    end
  endtask

  // Monitor: every handed-over result must match the head of the queue
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got=%0h expected=none at %0t", bus.inputALU, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_code", 32'(bus.inputALU), 32'(e.code));
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        chk("result_illegal", 32'(bus.illegal), 32'(e.ill));
`endif
      end
    end
  end

  initial begin
    int w;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.OpALU    = 2'b00;
    bus.funct    = '0;
    bus.out_ready = 1'b1;

    // Reset values
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_inputALU", 32'(bus.inputALU), 0);
    chk("rst_busy", 32'(bus.busy), 0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    chk("rst_err_sticky", 32'(bus.err_sticky), 0);
`endif
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // First ADD after release
    send(OP_RTYPE, F_ADD, ALU_ADD, 1'b0, w);

    // Back-to-back single-cycle ops
    send(OP_RTYPE, F_ADD, ALU_ADD, 1'b0, w); chk("b2b_wait_add", 32'(w), 0);
    send(OP_RTYPE, F_SUB, ALU_SUB, 1'b0, w); chk("b2b_wait_sub", 32'(w), 0);
    send(OP_RTYPE, F_AND, ALU_AND, 1'b0, w); chk("b2b_wait_and", 32'(w), 0);
    send(OP_RTYPE, F_OR,  ALU_OR,  1'b0, w); chk("b2b_wait_or",  32'(w), 0);
    send(OP_RTYPE, F_SLT, ALU_SLT, 1'b0, w); chk("b2b_wait_slt", 32'(w), 0);
    send(OP_RTYPE, F_NOR, ALU_NOR, 1'b0, w); chk("b2b_wait_nor", 32'(w), 0);

    // MULT latency
    send(OP_RTYPE, F_MULT, ALU_MULT, 1'b0, w);
    for (int k = 1; k < int'(MUL_LAT); k++) begin
      @(negedge clk);
      chk("mult_busy", 32'(bus.busy), 1);
      chk("mult_in_ready", 32'(bus.in_ready), 0);
      chk("mult_out_valid", 32'(bus.out_valid), 0);
    end
    @(negedge clk);
    chk("mult_done_valid", 32'(bus.out_valid), 1);
    chk("mult_done_busy", 32'(bus.busy), 0);
    tick();

    // DIV latency
    send(OP_RTYPE, F_DIV, ALU_DIV, 1'b0, w);
    for (int k = 1; k < int'(DIV_LAT); k++) begin
      @(negedge clk);
      chk("div_busy", 32'(bus.busy), 1);
      chk("div_out_valid", 32'(bus.out_valid), 0);
      chk("div_inputALU_frozen", 32'(bus.inputALU), 32'(ALU_DIV));
    end
    @(negedge clk);
    chk("div_done_valid", 32'(bus.out_valid), 1);
    tick();

    // Backpressure: ADD result held three cycles, pending SUB waits
    send(OP_RTYPE, F_ADD, ALU_ADD, 1'b0, w);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.OpALU     = OP_RTYPE;
    bus.funct     = F_SUB;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_code", 32'(bus.inputALU), 32'(ALU_ADD));
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
    end
    tick();
    bus.out_ready = 1'b1;
    exp_q.push_back('{ill: 1'b0, code: ALU_SUB});
    @(negedge clk);
    chk("bp_release_in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;

    // Mem and branch classes ignore funct
    for (int k = 0; k < 3; k++) begin
      send(OP_MEM, 6'($urandom_range(63, 0)), ALU_ADD, 1'b0, w);
      send(OP_BRANCH, 6'($urandom_range(63, 0)), ALU_SUB, 1'b0, w);
    end

    // Illegal encodings
    send(OP_RSVD, F_ADD, ALU_AND, 1'b1, w);
    send(OP_RTYPE, 6'b111111, ALU_AND, 1'b1, w);
    send(OP_RTYPE, F_AND, ALU_AND, 1'b0, w);
    @(negedge clk);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    chk("err_sticky_set", 32'(bus.err_sticky), 1);
`endif
    tick();

    // Reset during HOLD discards the result
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.OpALU     = OP_RTYPE;
    bus.funct     = F_SLT;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("hold_pre_rst_valid", 32'(bus.out_valid), 1);
    chk("hold_pre_rst_code", 32'(bus.inputALU), 32'(ALU_SLT));
    #2 rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", 32'(bus.out_valid), 0);
    chk("hold_rst_code", 32'(bus.inputALU), 0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    chk("err_sticky_cleared", 32'(bus.err_sticky), 0);
`endif
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;

    // Reset during MULTI
    bus.in_valid = 1'b1;
    bus.OpALU    = OP_RTYPE;
    bus.funct    = F_MULT;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("multi_pre_rst_busy", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("multi_rst_busy", 32'(bus.busy), 0);
    chk("multi_rst_code", 32'(bus.inputALU), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    send(OP_RTYPE, F_OR, ALU_OR, 1'b0, w);

    // Drain
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (MUL_LAT + 2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised, handshaked successor to the single-cycle ALU control decoder.
- Accepts (OpALU, funct) on a valid/ready interface and produces a registered ALU select code.
- Adds multi-cycle operations (MULT/DIV) with a latency counter and busy indication.
- Sits between main control/ID stage and the ALU/multiplier datapath.

Parameters:
- CTRL_W, 4, width of ALU select code (>=4; upper bits zero-extended).
- FUNCT_W, 6, width of funct field.
- MUL_LAT, 4, cycles from accept to out_valid for MULT (>=2).
- DIV_LAT, 8, cycles from accept to out_valid for DIV (>=2).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept request this cycle.
- OpALU  input  2  ALU op class: 00 mem, 01 branch, 10 R-type, 11 reserved.
- funct  input  FUNCT_W  R-type function field.
- out_valid  output  1  inputALU valid.
- out_ready  input  1  consumer takes result.
- inputALU  output  CTRL_W  ALU select code.
- busy  output  1  multi-cycle op in progress.

Behaviour:
- Reset (async, rst_n=0): state IDLE, inputALU=0, out_valid=0, busy=0, counter=0. in_ready=1 after release.
- Decode table (codes zero-extended to CTRL_W):
  - OpALU 00 -> 0010.
  - OpALU 01 -> 0110.
  - OpALU 11 -> 0000, treated as illegal.
  - OpALU 10, by funct:
    - 100000 -> 0010 (ADD)
    - 100010 -> 0110 (SUB)
    - 100100 -> 0000 (AND)
    - 100101 -> 0001 (OR)
    - 101010 -> 0111 (SLT)
    - 100111 -> 1100 (NOR)
    - 011000 -> 1000 (MULT, multi-cycle)
    - 011010 -> 1001 (DIV, multi-cycle)
    - other -> 0000 (illegal)
- States:
  - IDLE: in_ready=1.
    - Accept single-cycle op -> HOLD.
    - Accept MULT/DIV -> MULTI; counter loads LAT-1; busy=1.
  - MULTI: in_ready=0, out_valid=0, busy=1. Counter decrements each cycle; at 0 -> HOLD, busy=0.
  - HOLD: out_valid=1, inputALU stable.
    - out_ready=1 and in_valid=1: accept next request in the same cycle (in_ready=out_ready in HOLD), giving back-to-back throughput of 1/cycle for single-cycle ops. Next state is HOLD or MULTI per the new op.
    - out_ready=1 and in_valid=0 -> IDLE.
    - out_ready=0: hold everything.
- Latency:
  - Single-cycle ops: out_valid the cycle after accept.
  - MULT: out_valid MUL_LAT cycles after accept.
  - DIV: out_valid DIV_LAT cycles after accept.
- inputALU is registered at accept, held until the next accept; it does not change in MULTI.
- Inputs are ignored when in_valid=0 or in_ready=0.
- Reset asserted mid-MULTI or mid-HOLD: immediate return to reset values; the pending result is discarded.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_TRAP_EN.
- Defined: adds output port illegal (1 bit), registered alongside inputALU and valid with out_valid. Also adds sticky output err_sticky, set on any illegal accept and cleared only by reset. Both reset to 0.
- Undefined: neither port exists; illegal encodings silently map to 0000.

Decomposition:
- Package alu_ctrl_pkg holds:
  - OpALU class constants.
  - funct constants: ADD, SUB, AND, OR, SLT, NOR, MULT, DIV.
  - 4-bit ALU code constants.
  - state enum (IDLE, MULTI, HOLD).
  - is_multicycle helper function.
- One natural sub-module, alu_ctrl_decode: combinational (OpALU, funct) -> {code, multicycle, illegal}. It is reusable by the hazard unit.

Test Plan:
- Reset mid-op: release rst_n, OpALU=10 funct=100000 in_valid, out_ready=1 -> next cycle out_valid=1, inputALU=0010. Repeat and assert rst_n=0 during HOLD -> out_valid=0 and inputALU=0 immediately (async).
- Back-to-back: ADD, SUB, AND, OR, SLT issued on consecutive cycles with out_ready=1 -> outputs 0010, 0110, 0000, 0001, 0111 on consecutive cycles; in_ready stays 1.
- Multi-cycle: MULT (funct 011000) accepted at cycle t with MUL_LAT=4 -> busy=1 and in_ready=0 for t+1..t+3; out_valid=1 with inputALU=1000 at t+4. Repeat for DIV (DIV_LAT=8) -> inputALU=1001 at t+8.
- Backpressure: out_ready=0 for 3 cycles after an ADD result -> inputALU holds 0010, in_ready=0; a new SUB on in_valid is not accepted until out_ready=1.
- Illegal op: OpALU=11, then OpALU=10 funct=111111 -> inputALU=0000. With ALU_CTRL_ILLEGAL_TRAP_EN defined, illegal=1 with each result and err_sticky=1 remains set until reset.
- Mem and branch classes: OpALU=00 -> 0010; OpALU=01 -> 0110, with funct held at random values -> funct has no effect.
